// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: request/grant bus between the datapath write sources
// and the shared-register write arbiter.
//
// Handshake: a requester raises req[i] with data_in[i] and holds both stable
// until it sees ack while grant[i] is high, then drops req[i] in the cycle
// after ack. grant is one-hot (or zero when idle) and ack is a single-cycle
// pulse that marks the edge on which reg_q took the granted data.
// state_dbg mirrors the arbiter FSM encoding (0 IDLE, 1 GRANT, 2 WRITE).
interface reg_write_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] data_in;
    logic                     lock;
    logic [NUM_REQ-1:0]       grant;
    logic                     ack;
    logic [WIDTH-1:0]         reg_q;
    logic                     busy;
    logic [1:0]               state_dbg;

    // Requester side.
    modport master (
        output req, data_in, lock,
        input  grant, ack, reg_q, busy, state_dbg
    );

    // Arbiter side.
    modport slave (
        input  req, data_in, lock,
        output grant, ack, reg_q, busy, state_dbg
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter in front of one WIDTH-bit
// architectural register. A winner is granted on one edge, its data is
// committed (with ack) on the next, and the arbiter re-arbitrates straight
// out of WRITE so distinct requesters sustain one write every two cycles.
// The winner of a write is masked during that re-arbitration, so a single
// requester cannot own the register twice in a row.
//
// Optional feature macro: REG_ARB_LOCK_EN. When defined, a winner holding
// lock and req through its WRITE cycle goes straight back to GRANT without
// advancing the priority pointer. When undefined, lock is ignored.
module reg_write_arbiter #(
    parameter int               WIDTH       = 8,
    parameter int               NUM_REQ     = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                clock,
    input logic                reset_n,
    reg_write_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     winner_q, winner_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic [WIDTH-1:0]     reg_val_q, reg_val_d;

    logic [PTR_W:0]       pick_idle;
    logic [PTR_W:0]       pick_rearb;
    logic [PTR_W-1:0]     ptr_after;
    logic [WIDTH-1:0]     winner_data;
    logic                 relock;

    // Round-robin pick: first set bit at or above p, wrapping past NUM_REQ-1.
    // Result MSB flags that something was found; low bits are the index.
    function automatic logic [PTR_W:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [PTR_W-1:0]   p
    );
        logic [PTR_W:0] res;
        int             idx;
        res = '0;
        // Scan from the farthest candidate down so the nearest one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (r[idx]) begin
                res = {1'b1, PTR_W'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PTR_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Pointer value that takes effect once the current winner has written.
    assign ptr_after   = (winner_q == PTR_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
    assign winner_data = bus.data_in[int'(winner_q) * WIDTH +: WIDTH];

    // Winner re-entering GRANT under lock; constant zero without the feature.
`ifdef REG_ARB_LOCK_EN
    assign relock = bus.lock & bus.req[winner_q];
`else
    assign relock = 1'b0;
`endif

    // Arbitration candidates: fresh pick from IDLE, masked pick from WRITE.
    assign pick_idle  = rr_pick(bus.req, ptr_q);
    assign pick_rearb = rr_pick(bus.req & ~grant_q, ptr_after);

    // Next-state, grant, pointer and register update.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        winner_d  = winner_q;
        ptr_d     = ptr_q;
        ack_d     = 1'b0;
        reg_val_d = reg_val_q;

        unique case (state_q)
            IDLE: begin
                if (pick_idle[PTR_W]) begin
                    state_d  = GRANT;
                    winner_d = pick_idle[PTR_W-1:0];
                    grant_d  = to_onehot(pick_idle[PTR_W-1:0]);
                end
            end

            GRANT: begin
                if (bus.req[winner_q]) begin
                    // Commit; grant stays with the winner through WRITE.
                    state_d   = WRITE;
                    reg_val_d = winner_data;
                    ack_d     = 1'b1;
                end else begin
                    // Requester withdrew: drop ownership, pointer untouched.
                    state_d = IDLE;
                    grant_d = '0;
                end
            end

            WRITE: begin
                if (relock) begin
                    // Locked owner keeps the register; pointer not advanced.
                    state_d = GRANT;
                end else begin
                    ptr_d = ptr_after;
                    if (pick_rearb[PTR_W]) begin
                        state_d  = GRANT;
                        winner_d = pick_rearb[PTR_W-1:0];
                        grant_d  = to_onehot(pick_rearb[PTR_W-1:0]);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset discards any in-flight write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            winner_q  <= '0;
            ptr_q     <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            reg_val_q <= RESET_VALUE;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            winner_q  <= winner_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            reg_val_q <= reg_val_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.reg_q     = reg_val_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter. Each observation packs
// {state, grant, ack, busy, reg_q} into one 16-bit word and compares it
// with a hand-computed expectation.
module tb_reg_write_arbiter;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic        clock;
    logic        reset_n;
    int          tests_run;
    int          tests_failed;
    logic [15:0] obs;
    logic [15:0] exp_v;

    reg_write_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) bus ();

    reg_write_arbiter #(
        .WIDTH      (8),
        .NUM_REQ    (4),
        .RESET_VALUE(8'h00)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        bus.data_in[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        bus.req  = '0;
        bus.lock = 1'b0;
        reset_n  = 1'b0;
        tick();
        tick();
        reset_n  = 1'b1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b1;
        bus.req      = '0;
        bus.lock     = 1'b0;
        bus.data_in  = '0;
        #1 reset_n   = 1'b0;
        #2;
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_IDLE, 4'b0000, 1'b0, 1'b0, 8'h00};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_initial: got %h expected %h", obs, exp_v);
        end
        tick();
        reset_n = 1'b1;
        bus.req = 4'b0010;
        set_data(1, 8'h5C);
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_GRANT, 4'b0010, 1'b0, 1'b1, 8'h00};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_pre_grant: got %h expected %h", obs, exp_v);
        end
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_WRITE, 4'b0010, 1'b1, 1'b1, 8'h5C};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_pre_write: got %h expected %h", obs, exp_v);
        end
        // Assert reset mid-WRITE, well away from any clock edge.
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_IDLE, 4'b0000, 1'b0, 1'b0, 8'h00};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_async: got %h expected %h", obs, exp_v);
        end
        tick();
        reset_n = 1'b1;
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_GRANT, 4'b0010, 1'b0, 1'b1, 8'h00};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_release_grant: got %h expected %h", obs, exp_v);
        end
        bus.req = '0;
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_IDLE, 4'b0000, 1'b0, 1'b0, 8'h00};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_release_abort: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        bus.data_in = {8'hFF, 8'hA5, 8'hEE, 8'hDD};
        bus.req = 4'b0100;
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_GRANT, 4'b0100, 1'b0, 1'b1, 8'h00};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL single_grant: got %h expected %h", obs, exp_v);
        end
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_WRITE, 4'b0100, 1'b1, 1'b1, 8'hA5};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL single_commit: got %h expected %h", obs, exp_v);
        end
        bus.req = '0;
        set_data(2, 8'h3C);
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_IDLE, 4'b0000, 1'b0, 1'b0, 8'hA5};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL single_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] prev;
        do_reset();
        for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));
        bus.req = 4'b1111;
        prev = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
            exp_v = {S_GRANT, 4'(1 << i), 1'b0, 1'b1, prev};
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL rr_grant_%0d: got %h expected %h", i, obs, exp_v);
            end
            tick();
            prev = 8'h10 + 8'(i);
            tests_run++;
            obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
            exp_v = {S_WRITE, 4'(1 << i), 1'b1, 1'b1, prev};
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL rr_commit_%0d: got %h expected %h", i, obs, exp_v);
            end
            bus.req[i] = 1'b0;
        end
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_IDLE, 4'b0000, 1'b0, 1'b0, 8'h13};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL rr_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_abort();
        do_reset();
        set_data(0, 8'h77);
        set_data(1, 8'h88);
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0000;
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_IDLE, 4'b0000, 1'b0, 1'b0, 8'h00};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL abort_no_write: got %h expected %h", obs, exp_v);
        end
        bus.req = 4'b0011;
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_GRANT, 4'b0001, 1'b0, 1'b1, 8'h00};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL abort_ptr_kept: got %h expected %h", obs, exp_v);
        end
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_WRITE, 4'b0001, 1'b1, 1'b1, 8'h77};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL abort_commit0: got %h expected %h", obs, exp_v);
        end
        bus.req[0] = 1'b0;
        tick();
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_WRITE, 4'b0010, 1'b1, 1'b1, 8'h88};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL abort_commit1: got %h expected %h", obs, exp_v);
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_wrap_mask();
        do_reset();
        bus.data_in = {8'h33, 8'h22, 8'h11, 8'h30};
        bus.req = 4'b0100;
        tick();
        tick();
        bus.req = '0;
        tick();
        bus.req = 4'b1001;
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_GRANT, 4'b1000, 1'b0, 1'b1, 8'h22};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL wrap_grant3: got %h expected %h", obs, exp_v);
        end
        tick();
        bus.req[3] = 1'b0;
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_GRANT, 4'b0001, 1'b0, 1'b1, 8'h33};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL wrap_grant0: got %h expected %h", obs, exp_v);
        end
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_WRITE, 4'b0001, 1'b1, 1'b1, 8'h30};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL wrap_commit0: got %h expected %h", obs, exp_v);
        end
        bus.req = '0;
        tick();
        // Lone requester keeps req high across its own ack.
        set_data(1, 8'h41);
        bus.req = 4'b0010;
        tick();
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_WRITE, 4'b0010, 1'b1, 1'b1, 8'h41};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL mask_commit: got %h expected %h", obs, exp_v);
        end
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_IDLE, 4'b0000, 1'b0, 1'b0, 8'h41};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL mask_idle_gap: got %h expected %h", obs, exp_v);
        end
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_GRANT, 4'b0010, 1'b0, 1'b1, 8'h41};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL mask_regrant: got %h expected %h", obs, exp_v);
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        bus.lock = 1'b1;
        set_data(1, 8'h01);
        bus.req = 4'b0010;
        tick();
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
        exp_v = {S_WRITE, 4'b0010, 1'b1, 1'b1, 8'h01};
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL lock_first_commit: got %h expected %h", obs, exp_v);
        end
        set_data(1, 8'h02);
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
`ifdef REG_ARB_LOCK_EN
        exp_v = {S_GRANT, 4'b0010, 1'b0, 1'b1, 8'h01};
`else
        exp_v = {S_IDLE, 4'b0000, 1'b0, 1'b0, 8'h01};
`endif
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL lock_after_write: got %h expected %h", obs, exp_v);
        end
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
`ifdef REG_ARB_LOCK_EN
        exp_v = {S_WRITE, 4'b0010, 1'b1, 1'b1, 8'h02};
`else
        exp_v = {S_GRANT, 4'b0010, 1'b0, 1'b1, 8'h01};
`endif
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL lock_second: got %h expected %h", obs, exp_v);
        end
        bus.lock = 1'b0;
        bus.req  = '0;
        tick();
        tick();
        tests_run++;
        obs = {bus.state_dbg, bus.grant, bus.ack, bus.busy, bus.reg_q};
`ifdef REG_ARB_LOCK_EN
        exp_v = {S_IDLE, 4'b0000, 1'b0, 1'b0, 8'h02};
`else
        exp_v = {S_IDLE, 4'b0000, 1'b0, 1'b0, 8'h01};
`endif
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL lock_final: got %h expected %h", obs, exp_v);
        end
    endtask

    // Test sequence and final report
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_abort();
        test_wrap_mask();
        test_lock();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin write arbiter for one shared WIDTH-bit register built from rising-edge D flip-flops.
- Sits between CPU datapath sources (ALU result, data-bus load, index logic, interrupt vector logic) and a single architectural register.
- Grants one requester at a time, commits its data on a defined edge and acknowledges it; the register value is driven to all consumers.

Parameters:
WIDTH, 8, register and per-requester data width in bits
NUM_REQ, 4, number of requesters (2..8)
RESET_VALUE, 8'h00, register contents after reset

Ports:
clock  input  1  system clock; all state changes on rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester write request, level
data_in  input  NUM_REQ*WIDTH  flattened write data; requester i occupies bits [i*WIDTH +: WIDTH]
grant  output  NUM_REQ  one-hot current owner; all-zero when idle
ack  output  1  one-cycle pulse: granted data committed on this edge
reg_q  output  WIDTH  current register contents
busy  output  1  high in GRANT or WRITE state
lock  input  1  hold ownership (used only with REG_ARB_LOCK_EN; ignored otherwise)

Behaviour:
- Reset (reset_n low, any time, asynchronous):
  - state=IDLE, grant=0, ack=0, busy=0.
  - reg_q=RESET_VALUE, priority pointer=0.
  - Any in-flight write is discarded.
- States: IDLE, GRANT, WRITE. All outputs are registered.
- IDLE:
  - If any req bit is high at the edge, pick a winner by round robin: first set bit scanning from pointer upward with wrap (NUM_REQ-1 -> 0).
  - Go to GRANT; grant=onehot(winner).
  - If no req bit is high, stay in IDLE.
- GRANT:
  - If req[winner] is still high at the edge: reg_q <= data_in[winner]; go to WRITE; ack=1; grant held.
  - If req[winner] has dropped: abort. No write, grant=0, go to IDLE, pointer unchanged.
- WRITE (ack high for exactly this one cycle):
  - At the next edge, pointer <= winner+1 (mod NUM_REQ) and ack=0.
  - Re-arbitrate with req[winner] masked. If another request is pending, go directly to GRANT with the new one-hot grant; otherwise go to IDLE with grant=0.
- Latency and throughput:
  - Request to commit is 2 edges; ack is visible the cycle after commit.
  - Sustained throughput is one write per 2 cycles across different requesters.
  - The same requester cannot win twice back-to-back; it waits for an IDLE cycle or for another requester's turn.
- Requester contract: hold req and data_in stable from assertion until ack is seen, then deassert req in the cycle after ack.
  - req asserted during an ack cycle counts as a new request.
- reg_q changes only on a WRITE-entry edge or on reset. It never changes in IDLE or GRANT.
- grant is never multi-hot. grant is all-zero if and only if state is IDLE.
- data_in of non-granted requesters has no effect.

Optional Feature:
- Macro: REG_ARB_LOCK_EN.
- Defined:
  - In WRITE, if lock=1 and req[winner]=1 at the edge, the same winner returns directly to GRANT with the pointer not advanced. This allows back-to-back locked writes at one per 2 cycles.
  - Lock is ignored in IDLE and GRANT.
- Undefined: lock has no effect and the block behaves as described under Behaviour.

Test Plan:
- Reset: drive reset_n=0 mid-WRITE with req=4'b0010 -> reg_q=8'h00, grant=0, ack=0, busy=0 immediately, without waiting for a clock edge. Release reset_n -> IDLE, grant=4'b0010 one edge later.
- Single write: req=4'b0100, data_in[2]=8'hA5 -> grant=4'b0100 after edge 1; reg_q=8'hA5 and ack=1 after edge 2; grant=0 and ack=0 after edge 3.
- Round robin: req=4'b1111 held, data_in = 8'h10/8'h11/8'h12/8'h13 (requesters 0..3), each requester drops req after its ack -> grants issued in order 0,1,2,3. reg_q takes 8'h10, 8'h11, 8'h12, 8'h13 on consecutive WRITE edges, 2 cycles apart.
- Abort: req=4'b0001 then drop req[0] while in GRANT -> no ack, reg_q unchanged. Next request with req=4'b0011 grants requester 0 first, since the pointer did not advance.
- Wrap and mask: pointer=3 after requester 2 wins, then req=4'b1001 -> requester 3 granted, then requester 0. A lone requester 1 holding req across its own ack gets an IDLE gap before its next grant.
- With REG_ARB_LOCK_EN: lock=1, req=4'b0010, data 8'h01 then 8'h02 -> two acks 2 cycles apart, grant=4'b0010 throughout, reg_q=8'h02 at the end.
